// File: rtl/lcd_cmd_host_if.sv
// Handshake bundle between the LCD command host, its script ROM and the LCD controller.
// master = host side, slave = ROM/controller/harness side.
interface lcd_cmd_host_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              script_rd;
    logic [ADDR_W-1:0] script_A;
    logic [3:0]        script_Q;
    logic              busy;
    logic              done;
    logic [3:0]        cmd;
    logic              cmd_valid;
    logic [7:0]        issued_cnt;
    logic [7:0]        bad_cnt;
    logic              err;
    logic              finished;

    modport master (
        input  start, script_Q, busy, done,
        output script_rd, script_A, cmd, cmd_valid, issued_cnt, bad_cnt, err, finished
    );

    modport slave (
        output start, script_Q, busy, done,
        input  script_rd, script_A, cmd, cmd_valid, issued_cnt, bad_cnt, err, finished
    );
endinterface

// File: rtl/lcd_cmd_host.sv
// Script-driven command host: fetches 4-bit codes from a ROM and strobes them to the LCD controller.
// Latency: start->first cmd_valid 4 cycles, 5 cycles per legal command; issue stalls while busy, bounded by TIMEOUT.
module lcd_cmd_host #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    lcd_cmd_host_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam logic [TW-1:0]     T_LIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, WAIT_READY, ISSUE, GUARD, WAIT_DONE, FINISH
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [3:0]        cmd_reg, cmd_reg_nx;
    logic [3:0]        cmd_q;
    logic              cmd_valid_q;
    logic              rd_q;
    logic              fin_q;
    logic [TW-1:0]     tcnt;
    logic [7:0]        issued_q, bad_q;
    logic              err_q, err_set, bad_inc;
    logic              timed_out;

    // True on the TIMEOUT-th consecutive cycle spent in a wait state.
    assign timed_out = (tcnt == T_LIM);

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cmd_reg_nx = cmd_reg;
        err_set    = 1'b0;
        bad_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = FETCH;
                    ptr_nx   = '0;
                end
            end
            FETCH: state_nx = DECODE;
            DECODE: begin
                if (bus.script_Q < 4'd12) begin
                    cmd_reg_nx = bus.script_Q;
                    state_nx   = WAIT_READY;
                end else begin
                    bad_inc = 1'b1;
                    if (ptr == LAST) begin
                        cmd_reg_nx = '0;
                        err_set    = 1'b1;
                        state_nx   = WAIT_READY;
                    end else begin
                        ptr_nx   = ptr + ADDR_W'(1);
                        state_nx = FETCH;
                    end
                end
            end
            WAIT_READY: begin
                if (!bus.busy) begin
                    state_nx = ISSUE;
                end else if (timed_out) begin
                    err_set  = 1'b1;
                    state_nx = FINISH;
                end
            end
            ISSUE: state_nx = (cmd_reg == 4'd0) ? WAIT_DONE : GUARD;
            GUARD: begin
                // Script ran off the end without a WRITE: force one so the controller writes back.
                if (ptr == LAST) begin
                    cmd_reg_nx = '0;
                    err_set    = 1'b1;
                    state_nx   = WAIT_READY;
                end else begin
                    ptr_nx   = ptr + ADDR_W'(1);
                    state_nx = FETCH;
                end
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    state_nx = FINISH;
                end else if (timed_out) begin
                    err_set  = 1'b1;
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = FINISH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cmd_reg     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            rd_q        <= 1'b0;
            fin_q       <= 1'b0;
            tcnt        <= '0;
            issued_q    <= '0;
            bad_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            cmd_reg     <= cmd_reg_nx;
            cmd_valid_q <= (state_nx == ISSUE);
            rd_q        <= (state_nx == FETCH);
            fin_q       <= (state_nx == FINISH);
            if (state_nx == ISSUE) cmd_q <= cmd_reg;
            if (state_nx != state) begin
                tcnt <= '0;
            end else if (state == WAIT_READY || state == WAIT_DONE) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == ISSUE && issued_q != 8'hFF) issued_q <= issued_q + 8'd1;
            if (bad_inc && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
            err_q <= err_q | err_set;
        end
    end

    assign bus.script_rd  = rd_q;
    assign bus.script_A   = ptr;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.issued_cnt = issued_q;
    assign bus.bad_cnt    = bad_q;
    assign bus.err        = err_q;
    assign bus.finished   = fin_q;
endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: ROM + busy/done controller model, scenario tasks, and a script-level reference model.
module tb_lcd_cmd_host;
    localparam int AW   = 2;
    localparam int TO   = 16;
    localparam int LAST = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lcd_cmd_host_if #(.ADDR_W(AW)) bus ();
    lcd_cmd_host #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [3:0] rom [LAST+1];
    int busy_len   = 0;
    int done_delay = 0;
    bit busy_force = 1'b0;
    int cyc = 0, start_cyc = -1, fin_cyc = -1, hold_viol = 0;
    int q_cmd[$], q_cyc[$], e_cmd[$], e_cyc[$];
    int e_bad, e_fin;
    bit e_err;
    int n_tests = 0, n_fail = 0;

    // Script ROM: data appears the cycle after a read, garbage otherwise.
    initial begin
        bit rd;
        int a;
        bus.script_Q = 4'd0;
        forever begin
            @(negedge clk);
            rd = bus.script_rd;
            a  = int'(bus.script_A);
            @(posedge clk);
            #1;
            bus.script_Q = rd ? rom[a] : 4'($urandom);
        end
    end

    // Controller model and monitor, all on the falling edge; cyc numbers clock cycles.
    initial begin
        int busy_left;
        int done_left;
        bit done_now;
        logic [3:0] prev_cmd;
        busy_left = 0; done_left = 0; prev_cmd = 4'd0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                busy_left = 0;
                done_left = 0;
                prev_cmd  = bus.cmd;
                bus.busy  = busy_force;
                bus.done  = 1'b0;
            end else begin
                if (bus.start) start_cyc = cyc;
                if (bus.finished && fin_cyc < 0) fin_cyc = cyc;
                if (!bus.cmd_valid && bus.cmd !== prev_cmd) hold_viol++;
                prev_cmd = bus.cmd;
                done_now = 1'b0;
                if (done_left > 0) begin
                    done_left--;
                    done_now = (done_left == 0);
                end
                if (bus.cmd_valid) begin
                    q_cmd.push_back(int'(bus.cmd));
                    q_cyc.push_back(cyc);
                    busy_left = busy_len;
                    if (bus.cmd == 4'd0 && done_delay > 0) done_left = done_delay;
                end
                bus.done = done_now;
                bus.busy = busy_force || (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end
        end
    end

    // Reference: walk the script by its rules and time each step arithmetically.
    task automatic model_run();
        int ptr = 0, t, w, x, c = 0, ready_at;
        int cv;
        bit pend = 1'b0;
        e_cmd.delete(); e_cyc.delete();
        e_bad = 0; e_err = 1'b0; e_fin = -1;
        ready_at = busy_force ? (1 << 30) : -1;
        t = start_cyc + 1;
        forever begin
            if (pend) begin
                cv = 0;
                w  = c + 2;
            end else begin
                while (rom[ptr] >= 12 && ptr != LAST) begin
                    e_bad++; ptr++; t += 2;
                end
                if (rom[ptr] >= 12) begin
                    e_bad++; e_err = 1'b1; cv = 0;
                end else begin
                    cv = int'(rom[ptr]);
                end
                w = t + 2;
            end
            x = (ready_at > w) ? ready_at : w;
            if (x - w + 1 > TO) begin
                e_err = 1'b1; e_fin = w + TO;
                return;
            end
            c = x + 1;
            e_cmd.push_back(cv); e_cyc.push_back(c);
            ready_at = c + busy_len;
            if (cv == 0) begin
                if (done_delay >= 1 && done_delay <= TO) e_fin = c + done_delay + 1;
                else begin e_err = 1'b1; e_fin = c + 1 + TO; end
                return;
            end
            if (ptr == LAST) begin pend = 1'b1; e_err = 1'b1; end
            else begin ptr++; t = c + 2; end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic begin_run(input int s0, input int s1, input int s2, input int s3,
                             input int b, input int d, input bit f);
        rom[0] = 4'(s0); rom[1] = 4'(s1); rom[2] = 4'(s2); rom[3] = 4'(s3);
        busy_len = b; done_delay = d; busy_force = f;
        apply_reset();
        q_cmd.delete(); q_cyc.delete();
        fin_cyc = -1; hold_viol = 0; start_cyc = -1;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic run_script(input int s0, input int s1, input int s2, input int s3,
                              input int b, input int d, input bit f, output bit ok);
        begin_run(s0, s1, s2, s3, b, d, f);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.finished) break;
        end
        ok = bus.finished;
        @(negedge clk); #1;
        model_run();
    endtask

    task automatic test_reset();
        @(posedge clk); #1 reset = 1'b1; #1;
        n_tests++; if (bus.cmd !== 4'd0)        begin n_fail++; $display("FAIL reset_cmd: got %0d want 0", bus.cmd); end
        n_tests++; if (bus.cmd_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", bus.cmd_valid); end
        n_tests++; if (bus.script_rd !== 1'b0)  begin n_fail++; $display("FAIL reset_script_rd: got %b want 0", bus.script_rd); end
        n_tests++; if (bus.script_A !== '0)     begin n_fail++; $display("FAIL reset_script_A: got %0d want 0", bus.script_A); end
        n_tests++; if (bus.issued_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_issued: got %0d want 0", bus.issued_cnt); end
        n_tests++; if (bus.bad_cnt !== 8'd0)    begin n_fail++; $display("FAIL reset_bad: got %0d want 0", bus.bad_cnt); end
        n_tests++; if (bus.err !== 1'b0)        begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        n_tests++; if (bus.finished !== 1'b0)   begin n_fail++; $display("FAIL reset_finished: got %b want 0", bus.finished); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_basic_script();
        int want[4] = '{3, 1, 5, 0};
        bit ok;
        run_script(3, 1, 5, 0, 2, 10, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_finish: finished=%b want 1", bus.finished); end
        n_tests++; if (q_cmd.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", q_cmd.size()); end
        for (int i = 0; i < 4 && i < q_cmd.size(); i++) begin
            n_tests++; if (q_cmd[i] != want[i]) begin n_fail++; $display("FAIL basic_cmd[%0d]: got %0d want %0d", i, q_cmd[i], want[i]); end
            n_tests++; if (q_cyc[i] != e_cyc[i]) begin n_fail++; $display("FAIL basic_cyc[%0d]: got %0d want %0d", i, q_cyc[i], e_cyc[i]); end
        end
        n_tests++; if (q_cyc.size() > 0 && q_cyc[0] - start_cyc != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", q_cyc[0] - start_cyc); end
        n_tests++; if (bus.issued_cnt !== 8'd4) begin n_fail++; $display("FAIL basic_issued: got %0d want 4", bus.issued_cnt); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", bus.err); end
        n_tests++; if (q_cyc.size() == 4 && fin_cyc != q_cyc[3] + 11) begin n_fail++; $display("FAIL basic_fin_cyc: got %0d want %0d", fin_cyc, q_cyc[3] + 11); end
        n_tests++; if (hold_viol != 0) begin n_fail++; $display("FAIL basic_cmd_hold: got %0d changes want 0", hold_viol); end
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (q_cmd.size() != 4 || bus.finished !== 1'b1) begin n_fail++; $display("FAIL finish_start_ignored: strobes=%0d finished=%b want 4/1", q_cmd.size(), bus.finished); end
    endtask

    task automatic test_illegal_skip();
        bit ok;
        run_script(14, 4, 12, 0, 2, 5, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 2 || (q_cmd.size() == 2 && (q_cmd[0] != 4 || q_cmd[1] != 0))) begin n_fail++; $display("FAIL skip_cmds: got %p want '{4,0}", q_cmd); end
        n_tests++; if (bus.bad_cnt !== 8'd2) begin n_fail++; $display("FAIL skip_bad: got %0d want 2", bus.bad_cnt); end
        n_tests++; if (bus.issued_cnt !== 8'd2) begin n_fail++; $display("FAIL skip_issued: got %0d want 2", bus.issued_cnt); end
        n_tests++; if (bus.err !== 1'b0 || !ok) begin n_fail++; $display("FAIL skip_err_fin: err=%b fin=%b want 0/1", bus.err, ok); end
        n_tests++; if (q_cyc != e_cyc) begin n_fail++; $display("FAIL skip_cycles: got %p want %p", q_cyc, e_cyc); end
    endtask

    task automatic test_no_write();
        int want[5] = '{1, 2, 3, 4, 0};
        bit ok;
        run_script(1, 2, 3, 4, 2, 5, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 5) begin n_fail++; $display("FAIL nowrite_count: got %0d want 5", q_cmd.size()); end
        for (int i = 0; i < 5 && i < q_cmd.size(); i++) begin
            n_tests++; if (q_cmd[i] != want[i]) begin n_fail++; $display("FAIL nowrite_cmd[%0d]: got %0d want %0d", i, q_cmd[i], want[i]); end
        end
        n_tests++; if (bus.issued_cnt !== 8'd5 || bus.err !== 1'b1 || !ok) begin n_fail++; $display("FAIL nowrite_status: issued=%0d err=%b fin=%b want 5/1/1", bus.issued_cnt, bus.err, ok); end
        n_tests++; if (q_cyc != e_cyc || fin_cyc != e_fin) begin n_fail++; $display("FAIL nowrite_timing: got %p fin %0d want %p fin %0d", q_cyc, fin_cyc, e_cyc, e_fin); end
        run_script(1, 2, 3, 13, 0, 3, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 4 || (q_cmd.size() == 4 && q_cmd[3] != 0)) begin n_fail++; $display("FAIL forced_after_bad: got %p want '{1,2,3,0}", q_cmd); end
        n_tests++; if (bus.bad_cnt !== 8'd1 || bus.err !== 1'b1 || !ok) begin n_fail++; $display("FAIL forced_after_bad_status: bad=%0d err=%b fin=%b want 1/1/1", bus.bad_cnt, bus.err, ok); end
    endtask

    task automatic test_busy_timeout();
        bit ok;
        run_script(3, 1, 0, 0, 0, 5, 1'b1, ok);
        n_tests++; if (q_cmd.size() != 0) begin n_fail++; $display("FAIL busy_to_strobes: got %0d want 0", q_cmd.size()); end
        n_tests++; if (bus.err !== 1'b1 || !ok) begin n_fail++; $display("FAIL busy_to_status: err=%b fin=%b want 1/1", bus.err, ok); end
        n_tests++; if (fin_cyc - start_cyc != 3 + TO) begin n_fail++; $display("FAIL busy_to_cycle: got %0d want %0d", fin_cyc - start_cyc, 3 + TO); end
        busy_force = 1'b0;
    endtask

    task automatic test_done_timeout();
        int dl[4] = '{0, 16, 17, 1};
        bit ok, want_err;
        int want_gap;
        for (int k = 0; k < 4; k++) begin
            run_script(0, 9, 9, 9, 0, dl[k], 1'b0, ok);
            want_err = (dl[k] == 0 || dl[k] > TO);
            want_gap = want_err ? TO + 1 : dl[k] + 1;
            n_tests++; if (q_cmd.size() != 1 || (q_cmd.size() == 1 && q_cmd[0] != 0)) begin n_fail++; $display("FAIL done_to_strobe d=%0d: got %p want '{0}", dl[k], q_cmd); end
            n_tests++; if (bus.err !== want_err || !ok) begin n_fail++; $display("FAIL done_to_err d=%0d: err=%b fin=%b want %b/1", dl[k], bus.err, ok, want_err); end
            n_tests++; if (q_cyc.size() == 1 && fin_cyc - q_cyc[0] != want_gap) begin n_fail++; $display("FAIL done_to_gap d=%0d: got %0d want %0d", dl[k], fin_cyc - q_cyc[0], want_gap); end
        end
    endtask

    task automatic test_busy_boundary();
        bit ok;
        run_script(1, 0, 9, 9, 19, 4, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 2 || bus.err !== 1'b0) begin n_fail++; $display("FAIL busy_edge19: strobes=%0d err=%b want 2/0", q_cmd.size(), bus.err); end
        n_tests++; if (q_cyc.size() == 2 && q_cyc[1] - q_cyc[0] != 20) begin n_fail++; $display("FAIL busy_edge19_gap: got %0d want 20", q_cyc[1] - q_cyc[0]); end
        run_script(1, 0, 9, 9, 20, 4, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 1 || bus.err !== 1'b1 || !ok) begin n_fail++; $display("FAIL busy_edge20: strobes=%0d err=%b fin=%b want 1/1/1", q_cmd.size(), bus.err, ok); end
        n_tests++; if (q_cyc.size() == 1 && fin_cyc - q_cyc[0] != 4 + TO) begin n_fail++; $display("FAIL busy_edge20_fin: got %0d want %0d", fin_cyc - q_cyc[0], 4 + TO); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        run_script(3, 1, 5, 0, 0, 1, 1'b0, ok);
        n_tests++; if (q_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", q_cyc.size()); end
        for (int i = 0; i + 1 < q_cyc.size(); i++) begin
            n_tests++; if (q_cyc[i+1] - q_cyc[i] != 5) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, q_cyc[i+1] - q_cyc[i]); end
        end
        n_tests++; if (q_cyc.size() == 4 && fin_cyc - q_cyc[3] != 2) begin n_fail++; $display("FAIL b2b_done1: got %0d want 2", fin_cyc - q_cyc[3]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        begin_run(3, 1, 5, 0, 2, 0, 1'b0);
        for (int i = 0; i < 100 && q_cmd.size() < 4; i++) begin @(posedge clk); #1; end
        n_tests++; if (q_cmd.size() != 4) begin n_fail++; $display("FAIL mid_reach_wait_done: strobes=%0d want 4", q_cmd.size()); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; #1;
        n_tests++; if (bus.issued_cnt !== 8'd0 || bus.bad_cnt !== 8'd0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_counts: issued=%0d bad=%0d err=%b want 0/0/0", bus.issued_cnt, bus.bad_cnt, bus.err); end
        n_tests++; if (bus.cmd !== 4'd0 || bus.finished !== 1'b0 || bus.script_rd !== 1'b0) begin n_fail++; $display("FAIL mid_reset_outs: cmd=%0d fin=%b rd=%b want 0/0/0", bus.cmd, bus.finished, bus.script_rd); end
        @(posedge clk); #1 reset = 1'b0;
        run_script(3, 1, 5, 0, 2, 10, 1'b0, ok);
        n_tests++; if (q_cmd.size() != 4 || (q_cmd.size() == 4 && q_cmd[0] != 3)) begin n_fail++; $display("FAIL mid_rerun_cmds: got %p want '{3,1,5,0}", q_cmd); end
        n_tests++; if (bus.issued_cnt !== 8'd4 || bus.err !== 1'b0 || !ok) begin n_fail++; $display("FAIL mid_rerun_status: issued=%0d err=%b fin=%b want 4/0/1", bus.issued_cnt, bus.err, ok); end
        begin_run(7, 0, 0, 0, 0, 3, 1'b0);
        for (int i = 0; i < 20 && bus.cmd_valid !== 1'b1; i++) begin @(posedge clk); #1; end
        n_tests++; if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL async_strobe_seen: cmd_valid=%b want 1", bus.cmd_valid); end
        reset = 1'b1; #1;
        n_tests++; if (bus.cmd_valid !== 1'b0 || bus.cmd !== 4'd0) begin n_fail++; $display("FAIL async_drop: cmd_valid=%b cmd=%0d want 0/0", bus.cmd_valid, bus.cmd); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_random();
        int s[4];
        int b, d;
        bit ok;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 4; j++) s[j] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 10));
            d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            run_script(s[0], s[1], s[2], s[3], b, d, 1'b0, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd%0d_finish: finished=%b want 1", it, bus.finished); end
            n_tests++; if (q_cmd != e_cmd) begin n_fail++; $display("FAIL rnd%0d_cmds: got %p want %p", it, q_cmd, e_cmd); end
            n_tests++; if (q_cyc != e_cyc) begin n_fail++; $display("FAIL rnd%0d_cycles: got %p want %p", it, q_cyc, e_cyc); end
            n_tests++; if (int'(bus.issued_cnt) != e_cmd.size()) begin n_fail++; $display("FAIL rnd%0d_issued: got %0d want %0d", it, bus.issued_cnt, e_cmd.size()); end
            n_tests++; if (int'(bus.bad_cnt) != e_bad) begin n_fail++; $display("FAIL rnd%0d_bad: got %0d want %0d", it, bus.bad_cnt, e_bad); end
            n_tests++; if (bus.err !== e_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b want %b", it, bus.err, e_err); end
            n_tests++; if (fin_cyc != e_fin) begin n_fail++; $display("FAIL rnd%0d_fin_cyc: got %0d want %0d", it, fin_cyc, e_fin); end
            n_tests++; if (hold_viol != 0) begin n_fail++; $display("FAIL rnd%0d_cmd_hold: got %0d changes want 0", it, hold_viol); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i <= LAST; i++) rom[i] = 4'd0;
        test_reset();
        test_basic_script();
        test_illegal_skip();
        test_no_write();
        test_busy_timeout();
        test_done_timeout();
        test_busy_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
